// File: rtl/instruction_decoder_pipe.sv
// -----------------------------------------------------------------------------
// instruction_decoder_pipe
//
// Flow-controlled instruction decoder sitting between fetch and register-file
// read. Each accepted word is split into opcode, rD, flag, rA, rB and an
// immediate (sign- or zero-extended), and tagged illegal from a per-opcode
// mask. A 2-entry skid buffer keeps full throughput while in_ready stays a
// plain flop output. A saturating counter tallies completed output handshakes.
//
// Ports
//   clock        in   1         rising-edge clock
//   reset        in   1         synchronous, active-high
//   in_valid     in   1         instruction present
//   in_ready     out  1         decoder can accept (registered)
//   instruct     in   INSTR_W   instruction word
//   out_valid    out  1         decoded fields valid
//   out_ready    in   1         consumer accepts
//   opcode       out  OPC_W     instr[INSTR_W-1 -: OPC_W]
//   rDadrs       out  RADDR_W   bits below opcode
//   flag         out  1         bit below rD
//   rAadrs       out  RADDR_W   bits below flag
//   rBadrs       out  RADDR_W   bits below rA
//   imm          out  INSTR_W   instr[IMM_W-1:0], extended
//   illegal      out  1         ILLEGAL_MASK[opcode]
//   decode_count out  CNT_W     output handshakes, saturating
// -----------------------------------------------------------------------------
module instruction_decoder_pipe #(
    parameter int                  INSTR_W      = 16,
    parameter int                  OPC_W        = 4,
    parameter int                  RADDR_W      = 3,
    parameter int                  IMM_W        = 8,
    parameter int                  SEXT_IMM     = 1,
    parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0,
    parameter int                  CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [RADDR_W-1:0] rDadrs,
    output logic               flag,
    output logic [RADDR_W-1:0] rAadrs,
    output logic [RADDR_W-1:0] rBadrs,
    output logic [INSTR_W-1:0] imm,
    output logic               illegal,
    output logic [CNT_W-1:0]   decode_count
);

    // Field positions, packed downward from the MSB; the immediate may overlap.
    localparam int RD_HI  = INSTR_W - OPC_W - 1;
    localparam int FL_BIT = RD_HI - RADDR_W;
    localparam int RA_HI  = FL_BIT - 1;
    localparam int RB_HI  = RA_HI - RADDR_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [RADDR_W-1:0] rd;
        logic               flag;
        logic [RADDR_W-1:0] ra;
        logic [RADDR_W-1:0] rb;
        logic [INSTR_W-1:0] imm;
        logic               illegal;
    } dec_t;

    function automatic logic [INSTR_W-1:0] extend_imm(input logic [INSTR_W-1:0] word);
        logic [INSTR_W-1:0] ext;
        ext = (SEXT_IMM != 0 && word[IMM_W-1]) ? '1 : '0;
        ext[IMM_W-1:0] = word[IMM_W-1:0];
        return ext;
    endfunction

    function automatic dec_t decode(input logic [INSTR_W-1:0] word);
        dec_t d;
        d.opcode  = word[INSTR_W-1 -: OPC_W];
        d.rd      = word[RD_HI -: RADDR_W];
        d.flag    = word[FL_BIT];
        d.ra      = word[RA_HI -: RADDR_W];
        d.rb      = word[RB_HI -: RADDR_W];
        d.imm     = extend_imm(word);
        d.illegal = ILLEGAL_MASK[d.opcode];
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [1:0]  state, state_nxt;
    logic        acc, take;
    logic        load_out, load_skid, skid_to_out;
    dec_t        dec_p0;
    dec_t        out_p1, skid_p1;
    logic        vld_p1;
    logic [CNT_W-1:0] cnt_p1;

    // ---- stage 0: combinational decode of the incoming word ----
    assign dec_p0 = decode(instruct);
    assign acc    = in_valid && in_ready;
    assign take   = vld_p1 && out_ready;

    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                load_out  = 1'b1;
                state_nxt = ONE;
            end
            ONE: begin
                if (acc && take) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (take) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (take) begin
                skid_to_out = 1'b1;
                state_nxt   = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ---- stage 1: output register, skid register, control flops ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= EMPTY;
            vld_p1   <= 1'b0;
            in_ready <= 1'b1;
            out_p1   <= '0;
            skid_p1  <= '0;
            cnt_p1   <= '0;
        end else begin
            state    <= state_nxt;
            vld_p1   <= (state_nxt != EMPTY);
            // Computed from the next state so in_ready never sees out_ready combinationally.
            in_ready <= (state_nxt != FULL);
            if (load_out)         out_p1 <= dec_p0;
            else if (skid_to_out) out_p1 <= skid_p1;
            if (load_skid)        skid_p1 <= dec_p0;
            if (take)             cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_valid    = vld_p1;
    assign opcode       = out_p1.opcode;
    assign rDadrs       = out_p1.rd;
    assign flag         = out_p1.flag;
    assign rAadrs       = out_p1.ra;
    assign rBadrs       = out_p1.rb;
    assign imm          = out_p1.imm;
    assign illegal      = out_p1.illegal;
    assign decode_count = cnt_p1;

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Bench for instruction_decoder_pipe. Two instances share stimulus:
//   a: sign-extended immediate, ILLEGAL_MASK=16'h8001, 16-bit counter
//   b: zero-extended immediate, default mask, 4-bit counter
module tb_instruction_decoder_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] instruct;

    logic        a_in_ready, a_out_valid, a_flag, a_illegal;
    logic [3:0]  a_opcode;
    logic [2:0]  a_rd, a_ra, a_rb;
    logic [15:0] a_imm, a_count;

    logic        b_in_ready, b_out_valid, b_flag, b_illegal;
    logic [3:0]  b_opcode;
    logic [2:0]  b_rd, b_ra, b_rb;
    logic [15:0] b_imm;
    logic [3:0]  b_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instruction_decoder_pipe #(
        .SEXT_IMM(1), .ILLEGAL_MASK(16'h8001), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .instruct(instruct), .out_valid(a_out_valid), .out_ready(out_ready),
        .opcode(a_opcode), .rDadrs(a_rd), .flag(a_flag), .rAadrs(a_ra), .rBadrs(a_rb),
        .imm(a_imm), .illegal(a_illegal), .decode_count(a_count)
    );

    instruction_decoder_pipe #(
        .SEXT_IMM(0), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .instruct(instruct), .out_valid(b_out_valid), .out_ready(out_ready),
        .opcode(b_opcode), .rDadrs(b_rd), .flag(b_flag), .rAadrs(b_ra), .rBadrs(b_rb),
        .imm(b_imm), .illegal(b_illegal), .decode_count(b_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic        fl;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] imm_s;
        logic [15:0] imm_z;
        logic        ill;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hA5B4, 4'hA, 3'd2, 1'b1, 3'd5, 3'd5, 16'hFFB4, 16'h00B4, 1'b0};
        vecs[1] = '{16'h0000, 4'h0, 3'd0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 4'hF, 3'd7, 1'b1, 3'd7, 3'd7, 16'hFFFF, 16'h00FF, 1'b1};
        vecs[3] = '{16'h7E42, 4'h7, 3'd7, 1'b0, 3'd2, 3'd0, 16'h0042, 16'h0042, 1'b0};
        vecs[4] = '{16'h1381, 4'h1, 3'd1, 1'b1, 3'd4, 3'd0, 16'hFF81, 16'h0081, 1'b0};
        vecs[5] = '{16'h8C7F, 4'h8, 3'd6, 1'b0, 3'd3, 3'd7, 16'h007F, 16'h007F, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instruct = 16'h0;
        step();
        step();

        // Reset state
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_fields", {a_opcode, a_rd, a_flag, a_ra, a_rb}, 14'h0);
        check("rst_imm", a_imm, 16'h0);
        check("rst_illegal", a_illegal, 1'b0);
        check("rst_count", a_count, 16'h0);
        reset = 1'b0;

        // Table-driven decode, streamed back to back with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            instruct = vecs[i].instr;
            step();
            check($sformatf("v%0d_valid", i), a_out_valid, 1'b1);
            check($sformatf("v%0d_opcode", i), a_opcode, vecs[i].op);
            check($sformatf("v%0d_rd", i), a_rd, vecs[i].rd);
            check($sformatf("v%0d_flag", i), a_flag, vecs[i].fl);
            check($sformatf("v%0d_ra", i), a_ra, vecs[i].ra);
            check($sformatf("v%0d_rb", i), a_rb, vecs[i].rb);
            check($sformatf("v%0d_imm_sext", i), a_imm, vecs[i].imm_s);
            check($sformatf("v%0d_imm_zext", i), b_imm, vecs[i].imm_z);
            check($sformatf("v%0d_illegal_a", i), a_illegal, vecs[i].ill);
            check($sformatf("v%0d_illegal_b", i), b_illegal, 1'b0);
            check($sformatf("v%0d_in_ready", i), a_in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("vec_drain_valid", a_out_valid, 1'b0);
        check("vec_count", a_count, 16'd6);

        // Backpressure: three words with the consumer stalled
        pulse_reset();
        in_valid = 1'b1;
        instruct = 16'h1234;
        step();
        check("bp_w1_valid", a_out_valid, 1'b1);
        check("bp_w1_ready", a_in_ready, 1'b1);
        check("bp_w1_op", a_opcode, 4'h1);
        instruct = 16'h5678;
        step();
        check("bp_full_ready", a_in_ready, 1'b0);
        check("bp_hold_op", a_opcode, 4'h1);
        check("bp_hold_imm", a_imm, 16'h0034);
        instruct = 16'h9ABC;
        step();
        check("bp_stall_ready", a_in_ready, 1'b0);
        check("bp_stall_op", a_opcode, 4'h1);
        check("bp_stall_imm", a_imm, 16'h0034);
        check("bp_stall_count", a_count, 16'd0);
        out_ready = 1'b1;
        step();
        check("bp_w2_op", a_opcode, 4'h5);
        check("bp_w2_imm", a_imm, 16'h0078);
        check("bp_w2_ready", a_in_ready, 1'b1);
        step();
        check("bp_w3_op", a_opcode, 4'h9);
        check("bp_w3_imm", a_imm, 16'hFFBC);
        check("bp_w3_valid", a_out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        check("bp_empty_valid", a_out_valid, 1'b0);
        check("bp_count", a_count, 16'd3);

        // Continuous streaming of 100 words
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            in_valid = 1'b1;
            instruct = {8'h00, lo};
            step();
            check($sformatf("stream%0d", i), {a_in_ready, a_out_valid, a_imm[7:0]}, {1'b1, 1'b1, lo});
            if (i == 14 || i == 15 || i == 16)
                check($sformatf("sat_count_at_%0d", i), b_count, (i >= 15) ? 4'd15 : 4'(i));
            if (i == 50)
                check("stream_count_50", a_count, 16'd50);
        end
        in_valid = 1'b0;
        step();
        check("stream_count", a_count, 16'd100);
        check("stream_sat_hold", b_count, 4'd15);

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1;
        instruct = 16'hC3C3;
        step();
        instruct = 16'hD4D4;
        step();
        check("full_before_rst", a_in_ready, 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        check("frst_valid", a_out_valid, 1'b0);
        check("frst_ready", a_in_ready, 1'b1);
        check("frst_count", a_count, 16'd0);
        check("frst_op", a_opcode, 4'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("frst_no_stale", a_out_valid, 1'b0);
        step();
        check("frst_no_stale2", {a_out_valid, a_count}, 17'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
